// File: rtl/ctrl_conv_seq.sv
// ctrl_conv_seq -- per-sample sequencer for the ring-buffer RAM address driver and MAC.
//
// Each accepted input sample runs this sequence:
//   INIT  : one ring-buffer init cycle at the current head.
//   LOAD  : load the coefficient pointer for the current phase and clear the MAC.
//   CALC  : address counting until the RAM driver reports conv_pass.
//   DRAIN : wait MAC_LAT cycles for the MAC pipeline to empty.
//   DONE  : present the result on res_vld/res_rdy. Go to the next phase (LOAD),
//           or advance the ring-buffer head and return to IDLE.
//
// Ports
//   clk, rst_n                  clock; synchronous active-low reset
//   seg_base, seg_top           ring segment bounds (head wraps from top to base)
//   coef_base, coef_stride      phase-0 coefficient pointer, per-phase increment
//   cfg_nphase                  branches per sample (0 behaves as 1)
//   sample_vld / sample_rdy     input sample handshake (ready only in IDLE)
//   conv_pass                   convolution pass finished (from RAM driver)
//   en_init, ringbuf_init       RAM driver init strobes (INIT)
//   coeff_load, mac_clr         coefficient load / MAC clear strobes (LOAD)
//   en_calc                     RAM driver count enable (CALC)
//   data_hptr, coef_ptr         current head address / current coefficient pointer
//   res_vld / res_rdy, res_phase result handshake and phase index
//   err                         sticky watchdog error
//
// Optional feature: define SEQ_TIMEOUT_EN to add a CALC watchdog. If conv_pass
// does not arrive within 2**TO_WIDTH-1 CALC cycles, err is set and the sample
// is abandoned. No result is produced and the head does not advance.
// Without the macro, CALC waits indefinitely and err is tied to 0.
//
// All outputs are registered. Each strobe is set on the transition into the
// state that owns it, so it stays aligned with state_q.

module ctrl_conv_seq #(
    parameter int ADDR_WIDTH = 12,
    parameter int PH_WIDTH   = 4,
    parameter int MAC_LAT    = 2,
    parameter int TO_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] seg_base,
    input  logic [ADDR_WIDTH-1:0] seg_top,
    input  logic [ADDR_WIDTH-1:0] coef_base,
    input  logic [ADDR_WIDTH-1:0] coef_stride,
    input  logic [PH_WIDTH-1:0]   cfg_nphase,
    input  logic                  sample_vld,
    output logic                  sample_rdy,
    input  logic                  conv_pass,
    output logic                  en_init,
    output logic                  ringbuf_init,
    output logic                  coeff_load,
    output logic                  en_calc,
    output logic [ADDR_WIDTH-1:0] data_hptr,
    output logic [ADDR_WIDTH-1:0] coef_ptr,
    output logic                  mac_clr,
    output logic                  res_vld,
    input  logic                  res_rdy,
    output logic [PH_WIDTH-1:0]   res_phase,
    output logic                  err
);

    if (MAC_LAT < 1 || TO_WIDTH < 2) begin : g_bad_cfg
        $error("ctrl_conv_seq: MAC_LAT must be >= 1 and TO_WIDTH >= 2");
    end

    localparam int LW = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LOAD, S_CALC, S_DRAIN, S_DONE
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] hptr_q, coef_q;
    logic [PH_WIDTH-1:0]   phase_q;
    logic [LW-1:0]         lat_q;
    logic                  sample_rdy_q, en_init_q, ringbuf_init_q, coeff_load_q;
    logic                  en_calc_q, mac_clr_q, res_vld_q;

    // Head advance wraps only when the head sits exactly on seg_top. An
    // out-of-range head therefore keeps counting up until it passes seg_top.
    logic [ADDR_WIDTH-1:0] hptr_adv_d;
    logic [PH_WIDTH-1:0]   last_ph_d;
    assign hptr_adv_d = (hptr_q == seg_top) ? seg_base : hptr_q + 1'b1;
    assign last_ph_d  = (cfg_nphase == '0) ? '0 : cfg_nphase - 1'b1;

`ifdef SEQ_TIMEOUT_EN
    // The counter holds (CALC cycles - 1). Firing at 2**TO_WIDTH-2 means the
    // error is raised at the end of CALC cycle 2**TO_WIDTH-1.
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((1 << TO_WIDTH) - 2);
    logic [TO_WIDTH-1:0] to_q;
    logic                err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            hptr_q         <= seg_base;
            coef_q         <= coef_base;
            phase_q        <= '0;
            lat_q          <= '0;
            sample_rdy_q   <= 1'b1;
            en_init_q      <= 1'b0;
            ringbuf_init_q <= 1'b0;
            coeff_load_q   <= 1'b0;
            en_calc_q      <= 1'b0;
            mac_clr_q      <= 1'b0;
            res_vld_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            to_q           <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            // One-cycle strobes default low; the level outputs are handled per state.
            en_init_q      <= 1'b0;
            ringbuf_init_q <= 1'b0;
            coeff_load_q   <= 1'b0;
            mac_clr_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sample_vld && sample_rdy_q) begin
                        state_q        <= S_INIT;
                        sample_rdy_q   <= 1'b0;
                        en_init_q      <= 1'b1;
                        ringbuf_init_q <= 1'b1;
                        phase_q        <= '0;
                        coef_q         <= coef_base;
                    end
                end
                S_INIT: begin
                    state_q      <= S_LOAD;
                    coeff_load_q <= 1'b1;
                    mac_clr_q    <= 1'b1;
                end
                S_LOAD: begin
                    state_q   <= S_CALC;
                    en_calc_q <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    to_q      <= '0;
`endif
                end
                S_CALC: begin
                    if (conv_pass) begin
                        state_q   <= S_DRAIN;
                        en_calc_q <= 1'b0;
                        lat_q     <= LW'(MAC_LAT - 1);
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (to_q == TO_LAST) begin
                        state_q      <= S_IDLE;
                        en_calc_q    <= 1'b0;
                        sample_rdy_q <= 1'b1;
                        err_q        <= 1'b1;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (lat_q == '0) begin
                        state_q   <= S_DONE;
                        res_vld_q <= 1'b1;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_rdy) begin
                        res_vld_q <= 1'b0;
                        if (phase_q == last_ph_d) begin
                            state_q      <= S_IDLE;
                            sample_rdy_q <= 1'b1;
                            hptr_q       <= hptr_adv_d;
                        end else begin
                            state_q      <= S_LOAD;
                            phase_q      <= phase_q + 1'b1;
                            coef_q       <= coef_q + coef_stride;
                            coeff_load_q <= 1'b1;
                            mac_clr_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    sample_rdy_q <= 1'b1;
                    en_calc_q    <= 1'b0;
                    res_vld_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sample_rdy   = sample_rdy_q;
    assign en_init      = en_init_q;
    assign ringbuf_init = ringbuf_init_q;
    assign coeff_load   = coeff_load_q;
    assign en_calc      = en_calc_q;
    assign mac_clr      = mac_clr_q;
    assign res_vld      = res_vld_q;
    assign res_phase    = phase_q;
    assign data_hptr    = hptr_q;
    assign coef_ptr     = coef_q;
`ifdef SEQ_TIMEOUT_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_conv_seq.sv
// Self-checking bench for ctrl_conv_seq (MAC_LAT=2, TO_WIDTH=4).
// When a sample is driven, its expected phases and coefficient pointers are
// pushed to queues. They are popped as the DUT shows coeff_load and result
// handshakes. Outputs are sampled 1ns after the rising edge.

module tb_ctrl_conv_seq;
    localparam int AW = 12;
    localparam int PW = 4;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] seg_base, seg_top, coef_base, coef_stride;
    logic [PW-1:0] cfg_nphase;
    logic          sample_vld, sample_rdy, conv_pass;
    logic          en_init, ringbuf_init, coeff_load, en_calc, mac_clr;
    logic [AW-1:0] data_hptr, coef_ptr;
    logic          res_vld, res_rdy, err;
    logic [PW-1:0] res_phase;

    always #5 clk = ~clk;

    ctrl_conv_seq #(.ADDR_WIDTH(AW), .PH_WIDTH(PW), .MAC_LAT(ML), .TO_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_base(seg_base), .seg_top(seg_top),
        .coef_base(coef_base), .coef_stride(coef_stride), .cfg_nphase(cfg_nphase),
        .sample_vld(sample_vld), .sample_rdy(sample_rdy), .conv_pass(conv_pass),
        .en_init(en_init), .ringbuf_init(ringbuf_init), .coeff_load(coeff_load),
        .en_calc(en_calc), .data_hptr(data_hptr), .coef_ptr(coef_ptr), .mac_clr(mac_clr),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_phase(res_phase), .err(err)
    );

    int            n_chk = 0;
    int            n_err = 0;
    logic [AW-1:0] hptr_m;
    logic [PW-1:0] exp_ph_q[$];
    logic [AW-1:0] exp_cp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] adv(input logic [AW-1:0] h);
        return (h == seg_top) ? seg_base : h + 12'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rdy"}, 32'(sample_rdy), 32'd1);
        chk({tag, "_strb"}, 32'({en_init, ringbuf_init, coeff_load, en_calc, mac_clr}), 32'd0);
        chk({tag, "_vld"}, 32'(res_vld), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Drive one sample. The bench raises conv_pass during the c-th CALC cycle
    // and holds res_rdy low for the first `stall` cycles of the first result.
    task automatic run_sample(input int nph, input int c, input int stall);
        int            np;
        int            cyc;
        int            calc_cnt;
        int            stall_left;
        bit            acc;
        bit            done;
        bit            first;
        logic [PW-1:0] held;
        np = (nph == 0) ? 1 : nph;
        cfg_nphase = PW'(nph);
        for (int p = 0; p < np; p++) begin
            exp_ph_q.push_back(PW'(p));
            exp_cp_q.push_back(AW'(coef_base + AW'(p) * coef_stride));
        end
        hptr_m = adv(hptr_m);
        sample_vld = 1'b1;
        acc = 0; done = 0; first = 1; cyc = 0; calc_cnt = 0; stall_left = stall;
        held = '0;
        res_rdy = 1'b1;
        for (int g = 0; g < 400 && !done; g++) begin
            if (!acc) begin
                if (sample_rdy) begin
                    acc = 1;
                    cyc = 0;
                end
            end else begin
                sample_vld = 1'b0;
                if (sample_rdy) begin
                    chk("idle_no_vld", 32'(res_vld), 32'd0);
                    done = 1;
                end
                if (coeff_load) begin
                    chk("mac_clr", 32'(mac_clr), 32'd1);
                    if (exp_cp_q.size() == 0) chk("cp_underflow", 32'd1, 32'd0);
                    else chk("coef_ptr", 32'(coef_ptr), 32'(exp_cp_q.pop_front()));
                end
                if (en_calc) begin
                    calc_cnt++;
                    conv_pass = (calc_cnt >= c);
                end else begin
                    calc_cnt = 0;
                    conv_pass = 1'b0;
                end
                if (res_vld) begin
                    if (first) chk("latency", 32'(cyc), 32'(3 + c + ML));
                    first = 0;
                    if (stall_left > 0) begin
                        if (stall_left == stall) held = res_phase;
                        else chk("bp_phase_hold", 32'(res_phase), 32'(held));
                        chk("bp_sample_rdy", 32'(sample_rdy), 32'd0);
                        chk("bp_no_load", 32'(coeff_load), 32'd0);
                        res_rdy = 1'b0;
                        stall_left--;
                    end else begin
                        res_rdy = 1'b1;
                        if (exp_ph_q.size() == 0) chk("ph_underflow", 32'd1, 32'd0);
                        else chk("res_phase", 32'(res_phase), 32'(exp_ph_q.pop_front()));
                    end
                end else begin
                    res_rdy = 1'b1;
                end
            end
            if (!done) begin
                step();
                if (acc) cyc++;
            end
        end
        sample_vld = 1'b0;
        conv_pass = 1'b0;
        res_rdy = 1'b1;
        if (!done) chk("seq_timeout", 32'd0, 32'd1);
        chk("sb_ph_empty", 32'(exp_ph_q.size()), 32'd0);
        chk("sb_cp_empty", 32'(exp_cp_q.size()), 32'd0);
        chk("head", 32'(data_hptr), 32'(hptr_m));
        exp_ph_q.delete();
        exp_cp_q.delete();
    endtask

    // Start a sample, apply reset while in CALC, and check the reset state.
    task automatic reset_mid_calc(input logic [AW-1:0] base);
        bit seen;
        seen = 0;
        cfg_nphase = 4'd1;
        sample_vld = 1'b1;
        conv_pass = 1'b0;
        for (int g = 0; g < 50 && !seen; g++) begin
            step();
            if (!sample_rdy) sample_vld = 1'b0;
            if (en_calc) seen = 1;
        end
        chk("rst_reach_calc", 32'(seen), 32'd1);
        sample_vld = 1'b0;
        rst_n = 1'b0;
        seg_base = base;
        step();
        rst_n = 1'b1;
        chk_idle_outputs("rst_mid");
        chk("rst_mid_hptr", 32'(data_hptr), 32'(base));
        chk("rst_mid_cptr", 32'(coef_ptr), 32'(coef_base));
        chk("rst_mid_phase", 32'(res_phase), 32'd0);
        hptr_m = base;
        for (int i = 0; i < 8; i++) step();
        chk("rst_mid_quiet", 32'(res_vld), 32'd0);
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic run_timeout();
        int            ncalc;
        bit            vld_seen;
        bit            back;
        logic [AW-1:0] h0;
        h0 = data_hptr;
        ncalc = 0; vld_seen = 0; back = 0;
        cfg_nphase = 4'd1;
        conv_pass = 1'b0;
        sample_vld = 1'b1;
        step();
        sample_vld = 1'b0;
        for (int g = 0; g < 100 && !back; g++) begin
            if (en_calc) ncalc++;
            if (res_vld) vld_seen = 1;
            if (sample_rdy) back = 1;
            else step();
        end
        chk("to_back_idle", 32'(back), 32'd1);
        chk("to_calc_cycles", 32'(ncalc), 32'd15);
        chk("to_err", 32'(err), 32'd1);
        chk("to_no_vld", 32'(vld_seen), 32'd0);
        chk("to_head", 32'(data_hptr), 32'(h0));
        for (int i = 0; i < 4; i++) step();
        chk("to_err_sticky", 32'(err), 32'd1);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        seg_base = 12'h100; seg_top = 12'h103;
        coef_base = 12'h040; coef_stride = 12'h010;
        cfg_nphase = 4'd1;
        sample_vld = 1'b0; conv_pass = 1'b0; res_rdy = 1'b1;
        step(); step();
        rst_n = 1'b1;
        chk_idle_outputs("por");
        chk("por_hptr", 32'(data_hptr), 32'h100);
        chk("por_cptr", 32'(coef_ptr), 32'h040);
        hptr_m = 12'h100;

        run_sample(1, 8, 0);           // single phase, latency 13
        run_sample(3, 1, 0);           // three phases: coef 0x040/0x050/0x060
        run_sample(2, 3, 5);           // backpressure on the first result

        reset_mid_calc(12'h100);
        for (int i = 0; i < 5; i++) run_sample(1, 1, 0);  // wrap 101,102,103,100,101

        run_sample(0, 2, 0);           // nphase 0 behaves as 1
        coef_base = 12'hFF8;           // coefficient pointer wraps modulo 2**12
        run_sample(2, 4, 0);
        coef_base = 12'h040;

        seg_base = 12'h200; seg_top = 12'h203;   // head outside the new segment
        run_sample(1, 1, 0);
        run_sample(1, 2, 0);

`ifdef SEQ_TIMEOUT_EN
        run_timeout();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
